// File: rtl/sdr_audio_pkg.sv
// Shared types and default widths for the audio sigma-delta output path.
package sdr_audio_pkg;

  localparam int DEF_IW              = 16;
  localparam int DEF_LGFIFO          = 3;
  localparam int DEF_CLKS_PER_SAMPLE = 750;
  localparam int DEF_GAIN_BITS       = 8;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } audio_state_t;

endpackage

// File: rtl/audio_sdm_if.sv
// Baseband sample stream from the FM demodulator into the audio modulator (no backpressure).
interface audio_sdm_if
  import sdr_audio_pkg::*;
#(
  parameter int IW = DEF_IW
) ();

  logic          i_ce;
  logic [IW-1:0] i_sample;

  modport master (output i_ce, output i_sample);
  modport slave  (input  i_ce, input  i_sample);

endinterface

// File: rtl/sfifo.sv
// Synchronous FIFO, first-word fall-through; a read on a full FIFO frees room for a same-cycle write.
module sfifo #(
  parameter int BW     = 16,
  parameter int LGFLEN = 3
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr,
  input  logic [BW-1:0] i_data,
  input  logic          i_rd,
  output logic [BW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  logic [BW-1:0]   mem [2**LGFLEN];
  logic [LGFLEN:0] wr_ptr;
  logic [LGFLEN:0] rd_ptr;
  logic            rd_en;
  logic            wr_en;

  assign rd_en = i_rd && !o_empty;
  assign wr_en = i_wr && (!o_full || rd_en);

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[LGFLEN] != rd_ptr[LGFLEN]) &&
                   (wr_ptr[LGFLEN-1:0] == rd_ptr[LGFLEN-1:0]);
  assign o_data  = mem[rd_ptr[LGFLEN-1:0]];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[LGFLEN-1:0]] <= i_data;
  end

endmodule

// File: rtl/audio_sdm.sv
// First-order sigma-delta audio DAC with sample FIFO and soft-mute gain ramp.
// Define AUDIO_SDM_DITHER_EN to add LFSR dither as the accumulator carry-in.
//
// state     | meaning
// ----------|-------------------------------------------------
// MUTED     | gain 0, scaled sample forced 0, 50% bitstream
// RAMP_UP   | gain +1 per sample tick towards unity
// RUN       | unity gain, samples pass through
// RAMP_DOWN | gain -1 per sample tick towards 0
module audio_sdm
  import sdr_audio_pkg::*;
#(
  parameter int IW              = DEF_IW,
  parameter int LGFIFO          = DEF_LGFIFO,
  parameter int CLKS_PER_SAMPLE = DEF_CLKS_PER_SAMPLE,
  parameter int GAIN_BITS       = DEF_GAIN_BITS
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  audio_sdm_if.slave  s_in,
  input  logic        i_clr_err,
  output logic        o_pwm,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_muted
);

  localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [CW-1:0]        TICK_LAST = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [GAIN_BITS:0]   GAIN_MAX  = {1'b1, {GAIN_BITS{1'b0}}};

  logic [CW-1:0]                 tick_cnt;
  logic                          tick;
  logic                          tick_d;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [IW-1:0]                 fifo_dout;
  logic                          ovf_evt;
  logic                          unf_evt;
  logic signed [IW-1:0]          hold;
  logic [GAIN_BITS:0]            gain;
  logic [GAIN_BITS:0]            gain_nxt;
  audio_state_t                  state;
  audio_state_t                  state_nxt;
  logic signed [IW+GAIN_BITS-1:0] prod;
  logic [IW-1:0]                 scaled;
  logic [IW-1:0]                 acc;
  logic [IW:0]                   sum;
  logic                          cin;

  assign tick = (tick_cnt == TICK_LAST);

  sfifo #(
    .BW     (IW),
    .LGFLEN (LGFIFO)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wr      (s_in.i_ce),
    .i_data    (s_in.i_sample),
    .i_rd      (tick),
    .o_data    (fifo_dout),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  // A full FIFO still accepts the write when the tick pops in the same cycle.
  assign ovf_evt = s_in.i_ce && fifo_full && !tick;
  assign unf_evt = tick && fifo_empty && (state != MUTED);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= MUTED;
      gain  <= '0;
    end else begin
      state <= state_nxt;
      gain  <= gain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gain_nxt  = gain;
    case (state)
      MUTED: begin
        if (i_en) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (tick && (gain != GAIN_MAX)) gain_nxt = gain + 1'b1;
        if (!i_en)                 state_nxt = RAMP_DOWN;
        else if (gain == GAIN_MAX) state_nxt = RUN;
      end
      RUN: begin
        if (!i_en) state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (tick && (gain != '0)) gain_nxt = gain - 1'b1;
        if (i_en)              state_nxt = RAMP_UP;
        else if (gain == '0)   state_nxt = MUTED;
      end
      default: state_nxt = MUTED;
    endcase
  end

  // Product cannot exceed IW+GAIN_BITS signed bits because gain <= 2^GAIN_BITS.
  assign prod = hold * $signed({1'b0, gain});

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tick_cnt <= '0;
      tick_d   <= 1'b0;
      hold     <= '0;
      scaled   <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      tick_d   <= tick;
      if (tick && !fifo_empty) hold <= fifo_dout;
      if (state == MUTED)      scaled <= '0;
      else if (tick_d)         scaled <= IW'(prod >>> GAIN_BITS);
    end
  end

`ifdef AUDIO_SDM_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) lfsr <= 16'h0001;
    else            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign cin = lfsr[0];
`else
  assign cin = 1'b0;
`endif

  // Offset-binary input: signed zero sits at mid-scale, giving 50% density.
  assign sum = {1'b0, acc} + {1'b0, ~scaled[IW-1], scaled[IW-2:0]} + {{IW{1'b0}}, cin};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc         <= '0;
      o_pwm       <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      acc   <= sum[IW-1:0];
      o_pwm <= sum[IW];
      if (ovf_evt)        o_overflow <= 1'b1;
      else if (i_clr_err) o_overflow <= 1'b0;
      if (unf_evt)        o_underflow <= 1'b1;
      else if (i_clr_err) o_underflow <= 1'b0;
    end
  end

  assign o_muted = (state == MUTED);

endmodule

// File: tb/tb_audio_sdm.sv
// Directed bench for audio_sdm: mute idle pattern, FIFO overflow, ramp, density, underflow, async reset.
module tb_audio_sdm;
  import sdr_audio_pkg::*;

  localparam int CPS = 16;

  logic i_clk;
  logic i_reset_n;
  logic i_en;
  logic i_clr_err;
  logic o_pwm;
  logic o_overflow;
  logic o_underflow;
  logic o_muted;

  audio_sdm_if #(.IW(16)) sin ();

  audio_sdm #(
    .IW              (16),
    .LGFIFO          (3),
    .CLKS_PER_SAMPLE (CPS),
    .GAIN_BITS       (8)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_en        (i_en),
    .s_in        (sin),
    .i_clr_err   (i_clr_err),
    .o_pwm       (o_pwm),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow),
    .o_muted     (o_muted)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int tcnt   = 0;
  int ticks  = 0;

  // Bench view of the sample tick: counter 0..CPS-1, tick edge when it reads CPS-1.
  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tcnt = 0;
    end else if (tcnt == CPS - 1) begin
      tcnt  = 0;
      ticks = ticks + 1;
    end else begin
      tcnt = tcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge i_clk);
    #1;
  endtask

  // One clock; when feeding, push one sample per tick period at a fixed phase before the pop.
  task automatic step(input bit feed);
    edge1();
    sin.i_ce = feed && (tcnt == 3);
  endtask

  initial begin
    int   ones;
    int   toggles;
    int   t0;
    logic prev;

    i_reset_n    = 1'b0;
    i_en         = 1'b0;
    i_clr_err    = 1'b0;
    sin.i_ce     = 1'b0;
    sin.i_sample = 16'h4000;

    edge1();
    edge1();
    check("rst_muted", o_muted, 1);
    check("rst_pwm", o_pwm, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_unf", o_underflow, 0);
    i_reset_n = 1'b1;

    // Muted idle: bitstream alternates every clock, empty ticks do not flag underflow.
    for (int k = 0; k < 4; k++) step(0);
    prev    = o_pwm;
    toggles = 0;
    for (int k = 0; k < 2000; k++) begin
      step(0);
      if (o_pwm !== prev) toggles++;
      prev = o_pwm;
    end
    check("mute_toggles", toggles, 2000);
    check("mute_muted", o_muted, 1);
    check("mute_ovf", o_overflow, 0);
    check("mute_unf", o_underflow, 0);

    // Nine back-to-back pushes between ticks into an empty 8-deep FIFO.
    for (int k = 0; k < 2 * CPS && tcnt != 0; k++) step(0);
    sin.i_ce = 1'b1;
    for (int k = 0; k < 8; k++) edge1();
    check("ovf_after8", o_overflow, 0);
    edge1();
    check("ovf_after9", o_overflow, 1);
    sin.i_ce  = 1'b0;
    i_clr_err = 1'b1;
    edge1();
    i_clr_err = 1'b0;
    check("ovf_cleared", o_overflow, 0);
    for (int k = 0; k < 2 * CPS && tcnt != CPS - 1; k++) step(0);
    sin.i_ce = 1'b1;
    edge1();
    sin.i_ce = 1'b0;
    check("ovf_full_push_pop", o_overflow, 0);
    for (int k = 0; k < 10 * CPS; k++) step(0);
    check("mute_drain_unf", o_underflow, 0);

    // Ramp up to unity gain with one sample per tick.
    for (int k = 0; k < 2 * CPS && tcnt != 3; k++) step(0);
    i_en     = 1'b1;
    sin.i_ce = 1'b1;
    edge1();
    sin.i_ce = 1'b0;
    t0 = ticks;
    for (int k = 0; k < 6000 && dut.state != RUN; k++) step(1);
    check("ramp_state_run", dut.state, RUN);
    check("ramp_ticks", ticks - t0, 256);
    check("ramp_gain", dut.gain, 256);
    check("ramp_unmuted", o_muted, 0);
    check("ramp_unf", o_underflow, 0);

    // 16'h4000 at unity gain -> offset 16'hC000 -> 75% ones.
    ones = 0;
    for (int k = 0; k < 4096; k++) begin
      step(1);
      ones += int'(o_pwm);
    end
    check("run_density", (ones >= 3031 && ones <= 3113), 1);

    // Starve the FIFO: underflow sticks, hold keeps the last sample.
    for (int k = 0; k < 20 * CPS; k++) step(0);
    check("unf_set", o_underflow, 1);
    check("unf_hold", dut.hold, 32'h4000);
    check("unf_ovf", o_overflow, 0);
    ones = 0;
    for (int k = 0; k < 1024; k++) begin
      step(0);
      ones += int'(o_pwm);
    end
    check("unf_density", (ones >= 758 && ones <= 778), 1);

    for (int k = 0; k < 2 * CPS; k++) step(1);
    i_clr_err = 1'b1;
    step(1);
    i_clr_err = 1'b0;
    check("unf_cleared", o_underflow, 0);
    for (int k = 0; k < 4 * CPS; k++) step(1);
    check("unf_stays_clear", o_underflow, 0);

    // Asynchronous reset mid-RUN with a flag set and o_pwm high.
    for (int k = 0; k < 3 * CPS; k++) step(0);
    check("pre_rst_unf", o_underflow, 1);
    for (int k = 0; k < 8 && o_pwm !== 1'b1; k++) step(0);
    #3;
    i_reset_n = 1'b0;
    #1;
    check("arst_muted", o_muted, 1);
    check("arst_pwm", o_pwm, 0);
    check("arst_unf", o_underflow, 0);
    check("arst_ovf", o_overflow, 0);
    check("arst_gain", dut.gain, 0);
    edge1();
    i_reset_n = 1'b1;

    // Abort the ramp at gain 100: ramp down continuously from 100 to 0.
    for (int k = 0; k < 4000 && dut.gain != 100; k++) step(1);
    check("abort_gain100", dut.gain, 100);
    i_en = 1'b0;
    step(1);
    check("abort_state", dut.state, RAMP_DOWN);
    check("abort_gain_cont", dut.gain, 100);
    t0 = ticks;
    for (int k = 0; k < 3000 && o_muted !== 1'b1; k++) step(1);
    check("abort_muted", o_muted, 1);
    check("abort_ticks", ticks - t0, 100);
    check("abort_gain0", dut.gain, 0);
    check("abort_unf", o_underflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_sdm.md
AUDIO_SDM -- requirements
Module: audio_sdm

Interface
REQ-001 SHALL have parameter IW, default 16, meaning the signed audio sample width.
REQ-002 SHALL have parameter LGFIFO, default 3, meaning log2 of the sample FIFO depth.
REQ-003 SHALL have parameter CLKS_PER_SAMPLE, default 750, meaning clocks per audio sample tick (36 MHz / 48 kHz).
REQ-004 SHALL have parameter GAIN_BITS, default 8, meaning soft-mute gain resolution; unity gain = 2^GAIN_BITS.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port i_en, input, 1 bit: audio enable; low requests soft mute.
REQ-008 SHALL have port i_ce, input, 1 bit: sample strobe from the FM demodulator baseband stage; there is no backpressure.
REQ-009 SHALL have port i_sample, input, IW bits: signed baseband sample, valid when i_ce is high.
REQ-010 SHALL have port i_clr_err, input, 1 bit: clears both sticky error flags.
REQ-011 SHALL have port o_pwm, output, 1 bit: sigma-delta audio bitstream.
REQ-012 SHALL have port o_overflow, output, 1 bit: sticky flag, set when a sample was dropped.
REQ-013 SHALL have port o_underflow, output, 1 bit: sticky flag, set when a tick found the FIFO empty.
REQ-014 SHALL have port o_muted, output, 1 bit: high in state MUTED.

Function
REQ-015 SHALL buffer i_sample in a 2^LGFIFO-entry FIFO on each i_ce; on i_ce while full, SHALL drop the sample and set o_overflow.
REQ-016 SHALL run a tick counter 0..CLKS_PER_SAMPLE-1 that wraps and asserts tick on the cycle it reads CLKS_PER_SAMPLE-1.
REQ-017 On tick with the FIFO non-empty, SHALL pop one sample into the hold register; when empty, SHALL retain the previous hold value and set o_underflow, except in state MUTED.
REQ-018 When a push and a pop occur in the same cycle on a full FIFO, SHALL accept both with no overflow; on an empty FIFO, the pop SHALL underflow and the push SHALL be stored.
REQ-019 SHALL implement the mute FSM: MUTED -(i_en)-> RAMP_UP -(gain==2^GAIN_BITS)-> RUN -(!i_en)-> RAMP_DOWN -(gain==0)-> MUTED.
REQ-020 Deasserting i_en during RAMP_UP SHALL go directly to RAMP_DOWN; asserting it during RAMP_DOWN SHALL go directly to RAMP_UP; gain SHALL be continuous across these transitions.
REQ-021 Gain SHALL change by one step per tick only: +1 in RAMP_UP, -1 in RAMP_DOWN, and saturate at 0 and 2^GAIN_BITS.
REQ-022 Scaled sample SHALL be (hold × gain) >>> GAIN_BITS as a signed, full-precision product, registered one clock after tick.
REQ-023 The modulator SHALL be first order: an IW-bit accumulator adds the offset-binary scaled sample (MSB inverted) every clock, and o_pwm is the registered carry-out.
REQ-024 In MUTED, scaled sample SHALL be 0, so o_pwm toggles at 50% density.
REQ-025 i_clr_err SHALL clear the flags; a simultaneous set event SHALL win.

Reset
REQ-026 While i_reset_n is low, SHALL hold: FIFO empty, tick counter 0, hold 0, gain 0, FSM MUTED, accumulator 0, o_pwm 0, o_overflow 0, o_underflow 0, o_muted 1.
REQ-027 Reset asserted mid-ramp or mid-FIFO-fill SHALL discard all state immediately, with no ramp-down.

Configuration
REQ-028 With AUDIO_SDM_DITHER_EN defined, SHALL add bit 0 of a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'h0001) as accumulator carry-in every clock.
REQ-029 Without AUDIO_SDM_DITHER_EN, carry-in SHALL be 0 and no LFSR logic SHALL exist.

Structure
REQ-030 Package sdr_audio_pkg SHALL hold the FSM state enum (MUTED, RAMP_UP, RUN, RAMP_DOWN) and default width constants.
REQ-031 The FIFO SHALL be a separate sub-module, sfifo, with parameters BW and LGFLEN and full/empty outputs.

Verification
REQ-032 Reset, i_en=0, 2000 clocks -> o_muted=1, o_pwm alternating 0/1, both flags 0.
REQ-033 i_en=1, constant sample 16'h4000, one i_ce per tick -> RUN reached after 256 ticks; o_pwm density 75%±1% over the next 4096 clocks.
REQ-034 Push 9 samples in 9 consecutive clocks with LGFIFO=3 -> o_overflow=1 on the 9th; i_clr_err pulse -> 0.
REQ-035 RUN with no i_ce for 2 ticks -> o_underflow=1, hold unchanged; o_pwm density unchanged.
REQ-036 i_en drops at gain=100 in RAMP_UP -> RAMP_DOWN, gain reaches 0 after 100 ticks, then MUTED.
REQ-037 i_reset_n pulsed low asynchronously mid-RUN -> all outputs at reset values before the next i_clk edge.
